// File: rtl/ramio_arbiter.sv
// ramio_arbiter: shares the data port (port A) of the RAM/UART/LED I/O block
// between the CPU core (requester 0) and a DMA/boot-loader engine
// (requester 1). It grants round-robin, holds a bounded lock for atomic
// read-modify-write sequences, and steers returning read data back to the
// requester that issued the read.
module ramio_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0 (CPU core)
  input  logic                  r0_req,
  input  logic                  r0_lock,
  input  logic [1:0]            r0_we,
  input  logic [2:0]            r0_re,
  input  logic [ADDR_WIDTH+1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_din,
  output logic                  r0_gnt,
  output logic [DATA_WIDTH-1:0] r0_dout,
  output logic                  r0_dv,
  // requester 1 (DMA / boot loader)
  input  logic                  r1_req,
  input  logic                  r1_lock,
  input  logic [1:0]            r1_we,
  input  logic [2:0]            r1_re,
  input  logic [ADDR_WIDTH+1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_din,
  output logic                  r1_gnt,
  output logic [DATA_WIDTH-1:0] r1_dout,
  output logic                  r1_dv,
  // port A of the I/O block
  output logic [1:0]            weA,
  output logic [2:0]            reA,
  output logic [ADDR_WIDTH+1:0] addrA,
  output logic [DATA_WIDTH-1:0] dinA,
  input  logic [DATA_WIDTH-1:0] doutA
);

  // Counter value at which a held lock is forcibly released.
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_t;

  owner_t      owner;
  logic        last;      // requester granted most recently
  logic [7:0]  lock_cnt;  // cycles spent in the current owned period
  logic [1:0]  rd_tag;    // read issued last cycle, per requester
  logic        gnt0;
  logic        gnt1;
  logic        owner_lock;

  // The current owner still asks to keep the port.
  assign owner_lock = ((owner == OWN_0) && r0_lock) ||
                      ((owner == OWN_1) && r1_lock);

  // Same-cycle grant: round-robin when free, exclusive to the lock holder when owned.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (owner)
        OWN_NONE: begin
          if (r0_req && r1_req) begin
            gnt0 = last;
            gnt1 = !last;
          end else begin
            gnt0 = r0_req;
            gnt1 = r1_req;
          end
        end
        OWN_0:   gnt0 = r0_req;
        OWN_1:   gnt1 = r1_req;
        default: ;
      endcase
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  // Port A carries the accepted requester's access, or all zeros when idle.
  always_comb begin
    weA   = '0;
    reA   = '0;
    addrA = '0;
    dinA  = '0;
    if (gnt0) begin
      weA   = r0_we;
      reA   = r0_re;
      addrA = r0_addr;
      dinA  = r0_din;
    end else if (gnt1) begin
      weA   = r1_we;
      reA   = r1_re;
      addrA = r1_addr;
      dinA  = r1_din;
    end
  end

  // Ownership, round-robin pointer, lock timer and read tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= OWN_NONE;
      last     <= 1'b1;
      lock_cnt <= '0;
      rd_tag   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every decision
      // below sees the values from before this clock edge.
      rd_tag <= {gnt1 && (r1_re[1:0] != 2'b00),
                 gnt0 && (r0_re[1:0] != 2'b00)};
      case (owner)
        OWN_NONE: begin
          if (gnt0 || gnt1) begin
            last     <= gnt1;
            lock_cnt <= '0;
            if (gnt0 && r0_lock)      owner <= OWN_0;
            else if (gnt1 && r1_lock) owner <= OWN_1;
          end
        end
        OWN_0, OWN_1: begin
          lock_cnt <= lock_cnt + 8'd1;
          last     <= (owner == OWN_1);
          // A timed-out lock is dropped even if the holder still asks for it.
          if ((lock_cnt == LOCK_LAST) || !owner_lock) owner <= OWN_NONE;
        end
        default: owner <= OWN_NONE;
      endcase
    end
  end

  // Read data is steered only to the requester whose read it is; a read
  // issued just before reset never returns.
  assign r0_dv   = rd_tag[0] && !rst;
  assign r1_dv   = rd_tag[1] && !rst;
  assign r0_dout = r0_dv ? doutA : '0;
  assign r1_dout = r1_dv ? doutA : '0;

endmodule
